// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the EX_WB/decode side and the fetch sequencer.
// The sequencer takes the slave view; whoever drives hazard inputs takes master.
interface fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic [4:0]       ex_rd;
   logic             ex_is_load;
   logic             mc_start;
   logic             pc_we;
   logic             pc_load;
   logic [31:0]      pc_target;
   logic             if_id_we;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             busy;
   logic [CNT_W-1:0] stall_count;
   logic             err;

   modport master (
      output redirect_valid, redirect_pc, id_rs, id_rt, id_uses_rt,
             ex_rd, ex_is_load, mc_start,
      input  pc_we, pc_load, pc_target, if_id_we, if_id_flush,
             id_ex_bubble, busy, stall_count, err
   );

   modport slave (
      input  redirect_valid, redirect_pc, id_rs, id_rt, id_uses_rt,
             ex_rd, ex_is_load, mc_start,
      output pc_we, pc_load, pc_target, if_id_we, if_id_flush,
             id_ex_bubble, busy, stall_count, err
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage / IF_ID sequencer: branch redirect flush, load-use stalls and
// multi-cycle EX stalls. Outputs are combinational from state and inputs.
module fetch_ctrl #(
   parameter int FLUSH_CYC = 1,
   parameter int MC_LAT    = 4,
   parameter int CNT_W     = 16
) (
   input  logic          clock,
   input  logic          reset,
   fetch_ctrl_if.slave   bus
);

   localparam int CNT_MAX = (MC_LAT > FLUSH_CYC) ? MC_LAT : FLUSH_CYC;
   localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CW-1:0] FLUSH_RLD = CW'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);
   localparam logic [CW-1:0] MC_RLD    = CW'(MC_LAT - 1);

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      STALL_MC
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             err_q, err_d;

   logic pc_we, pc_load, if_id_we, if_id_flush, id_ex_bubble, lu;

   assign lu = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
               ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      pc_we        = 1'b0;
      pc_load      = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;

      if (reset) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (bus.redirect_valid) begin
                  pc_we        = 1'b1;
                  pc_load      = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     state_d = FLUSH;
                     cnt_d   = FLUSH_RLD;
                  end
               end else if (bus.mc_start) begin
                  id_ex_bubble = 1'b1;
                  state_d      = STALL_MC;
                  cnt_d        = MC_RLD;
               end else if (lu) begin
                  id_ex_bubble = 1'b1;
               end else begin
                  pc_we    = 1'b1;
                  if_id_we = 1'b1;
               end
            end
            FLUSH: begin
               pc_we        = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (bus.redirect_valid) begin
                  pc_load = 1'b1;
                  cnt_d   = FLUSH_RLD;
               end else if (cnt_q == '0) begin
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            STALL_MC: begin
               id_ex_bubble = 1'b1;
               // Redirect/mc_start here cannot be honoured; flag and keep stalling.
               if (bus.redirect_valid || bus.mc_start) err_d = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = RUN;
         endcase
      end

      stall_count_d = stall_count_q;
      if (!reset && !pc_we && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         stall_count_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stall_count_q <= stall_count_d;
         err_q         <= err_d;
      end
   end

   assign bus.pc_we        = pc_we;
   assign bus.pc_load      = pc_load;
   assign bus.pc_target    = bus.redirect_pc;
   assign bus.if_id_we     = if_id_we;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.busy         = (state_q != RUN);
   assign bus.stall_count  = stall_count_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked
// against a remaining-cycles reference model of the pipeline sequencer.
module tb_fetch_ctrl;

   localparam int FLUSH_CYC = 2;
   localparam int MC_LAT    = 4;
   localparam int CNT_W     = 3;
   localparam int SAT       = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   // reference model: cycles of flush / multi-cycle stall still owed
   int   flush_left = 0;
   int   mc_left    = 0;
   int   scnt       = 0;
   bit   m_err      = 1'b0;

   always #5 clock = ~clock;

   fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

   fetch_ctrl #(
      .FLUSH_CYC (FLUSH_CYC),
      .MC_LAT    (MC_LAT),
      .CNT_W     (CNT_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [31:0] rpc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic ld, input logic mc);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.id_rs          = rs;
      bus.id_rt          = rt;
      bus.id_uses_rt     = urt;
      bus.ex_rd          = rd;
      bus.ex_is_load     = ld;
      bus.mc_start       = mc;
   endtask

   // one clock cycle: apply inputs after the edge, check outputs at the falling edge
   task automatic step(input logic rv, input logic [31:0] rpc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                       input logic ld, input logic mc);
      logic e_we, e_ld, e_ifwe, e_fl, e_bub, e_busy, lu;
      int   n_fl, n_mc;
      bit   n_err;
      @(posedge clock);
      #1;
      drive(rv, rpc, rs, rt, urt, rd, ld, mc);
      @(negedge clock);
      lu = ld && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
      {e_we, e_ld, e_ifwe, e_fl, e_bub, e_busy} = '0;
      n_fl  = flush_left;
      n_mc  = mc_left;
      n_err = m_err;
      if (mc_left > 0) begin
         e_bub = 1; e_busy = 1; n_mc = mc_left - 1;
         if (rv || mc) n_err = 1;
      end else if (flush_left > 0) begin
         e_we = 1; e_fl = 1; e_bub = 1; e_busy = 1;
         if (rv) begin e_ld = 1; n_fl = FLUSH_CYC - 1; end
         else n_fl = flush_left - 1;
      end else if (rv) begin
         e_we = 1; e_ld = 1; e_fl = 1; e_bub = 1; n_fl = FLUSH_CYC - 1;
      end else if (mc) begin
         e_bub = 1; n_mc = MC_LAT;
      end else if (lu) begin
         e_bub = 1;
      end else begin
         e_we = 1; e_ifwe = 1;
      end
      chk("pc_we",        32'(bus.pc_we),        32'(e_we));
      chk("pc_load",      32'(bus.pc_load),      32'(e_ld));
      chk("pc_target",    bus.pc_target,         rpc);
      chk("if_id_we",     32'(bus.if_id_we && !bus.if_id_flush), 32'(e_ifwe));
      chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_fl));
      chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));
      chk("busy",         32'(bus.busy),         32'(e_busy));
      chk("stall_count",  32'(bus.stall_count),  32'(scnt));
      chk("err",          32'(bus.err),          32'(m_err));
      flush_left = n_fl;
      mc_left    = n_mc;
      m_err      = n_err;
      if (!e_we && scnt < SAT) scnt++;
   endtask

   task automatic idle();
      step(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
   endtask

   // async reset asserted between edges; reset-time outputs must appear immediately
   task automatic do_reset();
      @(posedge clock);
      #1;
      drive(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      reset = 1'b1;
      #1;
      chk("rst_busy",   32'(bus.busy),         32'd0);
      chk("rst_flush",  32'(bus.if_id_flush),  32'd1);
      chk("rst_pc_we",  32'(bus.pc_we),        32'd0);
      chk("rst_bubble", 32'(bus.id_ex_bubble), 32'd1);
      chk("rst_scnt",   32'(bus.stall_count),  32'd0);
      chk("rst_err",    32'(bus.err),          32'd0);
      flush_left = 0;
      mc_left    = 0;
      scnt       = 0;
      m_err      = 0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      drive(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      do_reset();
      idle();
      // load-use on rs, then same load with ex_rd=0
      step(0, 32'h0, 5'd3, 5'd0, 0, 5'd3, 1, 0);
      step(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 1, 0);
      chk("lu_scnt", 32'(bus.stall_count), 32'd1);
      // load-use on rt only when id_uses_rt
      step(0, 32'h0, 5'd1, 5'd7, 0, 5'd7, 1, 0);
      step(0, 32'h0, 5'd1, 5'd7, 1, 5'd7, 1, 0);
      // redirect with two-cycle flush
      step(1, 32'h0000_000C, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      idle();
      idle();
      // multi-cycle op: start cycle plus MC_LAT stall cycles
      step(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
      repeat (5) idle();
      // redirect beats mc_start and load-use in the same cycle
      step(1, 32'h0000_0100, 5'd2, 5'd0, 0, 5'd2, 1, 1);
      idle();
      idle();
      chk("no_mc_busy", 32'(bus.busy), 32'd0);
      // redirect during STALL_MC: sticky error, stall length unchanged
      step(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
      step(1, 32'h0000_0200, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      step(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
      repeat (4) idle();
      chk("err_sticky", 32'(bus.err), 32'd1);
      // saturating stall counter
      repeat (10) step(0, 32'h0, 5'd4, 5'd0, 0, 5'd4, 1, 0);
      chk("sat_scnt", 32'(bus.stall_count), 32'(SAT));
      // reset in the middle of a multi-cycle stall, then normal run
      step(0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
      idle();
      do_reset();
      idle();
      idle();
      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) == 0, $urandom,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0) do_reset();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
